// File: rtl/alarm_pkg.sv
// alarm_pkg
//   Shared definitions for the alarm sequencer:
//   - state_t: FSM states (IDLE, CHIME, ALARM, SNOOZE) with fixed debug encoding
//   - TONE_*: tone-select codes for the sound generator
//   - CHIME_MINUTE / CHIME_SECOND: time of the hourly chime (xx:59:59)
//   - CNT_W / SNZ_W: widths of the seconds countdown and the snooze counter
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHIME  = 2'd1,
    ALARM  = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  localparam logic [1:0] TONE_OFF   = 2'd0;
  localparam logic [1:0] TONE_CHIME = 2'd1;
  localparam logic [1:0] TONE_ALARM = 2'd2;

  localparam logic [5:0] CHIME_MINUTE = 6'd59;
  localparam logic [5:0] CHIME_SECOND = 6'd59;

  localparam int CNT_W = 10;
  localparam int SNZ_W = 3;

endpackage

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
//   Bundles the time inputs, alarm settings, user pulses and sound-generator
//   outputs of the alarm sequencer.
//   master: the surrounding clock logic (drives time/settings/pulses).
//   slave : the alarm sequencer (drives sound_en, tone_sel, LEDAlarm,
//           snooze_pend, state_o).
interface alarm_sequencer_if;

  logic       tick_1hz;
  logic [5:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [5:0] hour_set;
  logic [5:0] minute_set;
  logic [5:0] second_set;
  logic       alarm_set;
  logic       alarm_arm;
  logic       chime_en;
  logic       stop;
  logic       snooze;
  logic       sound_en;
  logic [1:0] tone_sel;
  logic       LEDAlarm;
  logic       snooze_pend;
  logic [1:0] state_o;

  modport master (
    output tick_1hz, hour, minute, second, hour_set, minute_set, second_set,
           alarm_set, alarm_arm, chime_en, stop, snooze,
    input  sound_en, tone_sel, LEDAlarm, snooze_pend, state_o
  );

  modport slave (
    input  tick_1hz, hour, minute, second, hour_set, minute_set, second_set,
           alarm_set, alarm_arm, chime_en, stop, snooze,
    output sound_en, tone_sel, LEDAlarm, snooze_pend, state_o
  );

endinterface

// File: rtl/alarm_sequencer_sec_countdown.sv
// sec_countdown
//   Loadable 10-bit seconds down-counter shared by the chime, alarm and
//   snooze durations.
//   Ports: clk, rst (async, active-high); tick (1 Hz strobe enables a
//   decrement); load/load_val (synchronous load, wins over tick);
//   expire (combinational pulse: counter is at 1 on a tick).
module sec_countdown
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Holds at zero rather than wrapping once the duration has run out.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Arbitrates the shared alarm sound/LED between the user alarm and the
//   hourly chime, times each ringing episode in seconds and handles
//   stop/snooze.
//   Ports: CLK_50 (50 MHz), rst (async, active-high), bus (slave modport):
//   time and alarm-time inputs, alarm_set/alarm_arm/chime_en levels,
//   stop/snooze pulses, tick_1hz strobe; outputs sound_en, tone_sel,
//   LEDAlarm, snooze_pend, state_o decoded from the registered state.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int ALARM_SEC  = 30,
  parameter int CHIME_SEC  = 3,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic               CLK_50,
  input  logic               rst,
  alarm_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] ALARM_LOAD  = CNT_W'(ALARM_SEC);
  localparam logic [CNT_W-1:0] CHIME_LOAD  = CNT_W'(CHIME_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [SNZ_W-1:0] MAX_SNZ     = SNZ_W'(MAX_SNOOZE);

  state_t           state_q, state_d;
  logic [SNZ_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [5:0]       alarm_hour_q, alarm_hour_d;
  logic [5:0]       alarm_minute_q, alarm_minute_d;
  logic [5:0]       alarm_second_q, alarm_second_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             expire;
  logic             alarm_match;
  logic             chime_match;

  always_comb begin
    alarm_hour_d   = alarm_hour_q;
    alarm_minute_d = alarm_minute_q;
    alarm_second_d = alarm_second_q;
    if (bus.alarm_set) begin
      alarm_hour_d   = bus.hour_set;
      alarm_minute_d = bus.minute_set;
      alarm_second_d = bus.second_set;
    end
  end

  assign alarm_match = bus.tick_1hz && bus.alarm_arm && !bus.alarm_set &&
                       (bus.hour == alarm_hour_q) &&
                       (bus.minute == alarm_minute_q) &&
                       (bus.second == alarm_second_q);

  assign chime_match = bus.tick_1hz && bus.chime_en &&
                       (bus.minute == CHIME_MINUTE) &&
                       (bus.second == CHIME_SECOND);

  // Every return to IDLE also loads zero so the countdown is parked and
  // cannot raise a stray expire later.
  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (bus.alarm_set) begin
      state_d      = IDLE;
      snooze_cnt_d = '0;
      cnt_load     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_match) begin
            state_d      = ALARM;
            snooze_cnt_d = '0;
            cnt_load     = 1'b1;
            cnt_load_val = ALARM_LOAD;
          end else if (chime_match) begin
            state_d      = CHIME;
            cnt_load     = 1'b1;
            cnt_load_val = CHIME_LOAD;
          end
        end
        CHIME: begin
          if (bus.stop || (!alarm_match && expire)) begin
            state_d      = IDLE;
            snooze_cnt_d = '0;
            cnt_load     = 1'b1;
          end else if (alarm_match) begin
            state_d      = ALARM;
            snooze_cnt_d = '0;
            cnt_load     = 1'b1;
            cnt_load_val = ALARM_LOAD;
          end
        end
        ALARM: begin
          if (bus.snooze && !bus.stop && (snooze_cnt_q < MAX_SNZ)) begin
            state_d      = SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = SNOOZE_LOAD;
          end else if (bus.stop || bus.snooze || expire) begin
            // A snooze with no snoozes left behaves like stop.
            state_d      = IDLE;
            snooze_cnt_d = '0;
            cnt_load     = 1'b1;
          end
        end
        SNOOZE: begin
          if (bus.stop) begin
            state_d      = IDLE;
            snooze_cnt_d = '0;
            cnt_load     = 1'b1;
          end else if (expire) begin
            state_d      = ALARM;
            cnt_load     = 1'b1;
            cnt_load_val = ALARM_LOAD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      snooze_cnt_q   <= '0;
      alarm_hour_q   <= '0;
      alarm_minute_q <= '0;
      alarm_second_q <= '0;
    end else begin
      state_q        <= state_d;
      snooze_cnt_q   <= snooze_cnt_d;
      alarm_hour_q   <= alarm_hour_d;
      alarm_minute_q <= alarm_minute_d;
      alarm_second_q <= alarm_second_d;
    end
  end

  sec_countdown u_countdown (
    .clk      (CLK_50),
    .rst      (rst),
    .tick     (bus.tick_1hz),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .expire   (expire)
  );

  assign bus.sound_en    = (state_q == CHIME) || (state_q == ALARM);
  assign bus.tone_sel    = (state_q == CHIME) ? TONE_CHIME :
                           (state_q == ALARM) ? TONE_ALARM : TONE_OFF;
  assign bus.LEDAlarm    = bus.sound_en;
  assign bus.snooze_pend = (state_q == SNOOZE);
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
//   Directed scenarios plus randomized stimulus for alarm_sequencer, checked
//   against a reference model that tracks time as seconds-of-day and ring
//   episodes as absolute tick deadlines.
module tb_alarm_sequencer;

  localparam int P_ALARM  = 5;
  localparam int P_CHIME  = 3;
  localparam int P_SNOOZE = 4;
  localparam int P_MAXSNZ = 1;

  localparam int M_IDLE   = 0;
  localparam int M_CHIME  = 1;
  localparam int M_ALARM  = 2;
  localparam int M_SNOOZE = 3;

  logic clk;
  logic rst;
  alarm_sequencer_if bus ();

  alarm_sequencer #(
    .ALARM_SEC  (P_ALARM),
    .CHIME_SEC  (P_CHIME),
    .SNOOZE_SEC (P_SNOOZE),
    .MAX_SNOOZE (P_MAXSNZ)
  ) dut (
    .CLK_50 (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] obs_vec;
  assign obs_vec = {bus.sound_en, bus.tone_sel, bus.LEDAlarm, bus.snooze_pend, bus.state_o};

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int sod = 0;       // current time, seconds of day
  int m_mode = 0;
  int m_end = 0;     // tick number on which the current episode ends
  int m_tick = 0;    // number of 1 Hz ticks seen
  int m_used = 0;    // snoozes used in the current alarm event
  int m_alarm = 0;   // stored alarm time, seconds of day

  function automatic logic [6:0] exp_vec();
    logic snd;
    logic [1:0] tone;
    snd  = (m_mode == M_CHIME) || (m_mode == M_ALARM);
    tone = (m_mode == M_CHIME) ? 2'd1 : (m_mode == M_ALARM) ? 2'd2 : 2'd0;
    return {snd, tone, snd, (m_mode == M_SNOOZE), 2'(m_mode)};
  endfunction

  task automatic set_time(input int t);
    sod = ((t % 86400) + 86400) % 86400;
    bus.hour   = 6'(sod / 3600);
    bus.minute = 6'((sod / 60) % 60);
    bus.second = 6'(sod % 60);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_used = 0; m_alarm = 0; m_end = 0;
  endtask

  // Predicts the state after the coming clock edge from the inputs now driven.
  task automatic model_step();
    int tn;
    bit tk, amatch, cmatch, expire;
    tk     = bus.tick_1hz;
    tn     = m_tick + (tk ? 1 : 0);
    amatch = tk && bus.alarm_arm && !bus.alarm_set && (sod == m_alarm);
    cmatch = tk && bus.chime_en && ((sod % 3600) == 3599);
    expire = tk && (m_mode != M_IDLE) && (tn == m_end);
    if (bus.alarm_set) begin
      m_alarm = int'(bus.hour_set) * 3600 + int'(bus.minute_set) * 60 + int'(bus.second_set);
      m_mode = M_IDLE; m_used = 0;
    end else if (bus.stop && m_mode != M_IDLE) begin
      m_mode = M_IDLE; m_used = 0;
    end else if (bus.snooze && m_mode == M_ALARM) begin
      if (m_used < P_MAXSNZ) begin
        m_mode = M_SNOOZE; m_end = tn + P_SNOOZE; m_used++;
      end else begin
        m_mode = M_IDLE; m_used = 0;
      end
    end else if (amatch && (m_mode == M_IDLE || m_mode == M_CHIME)) begin
      m_mode = M_ALARM; m_end = tn + P_ALARM; m_used = 0;
    end else if (cmatch && m_mode == M_IDLE) begin
      m_mode = M_CHIME; m_end = tn + P_CHIME;
    end else if (expire) begin
      if (m_mode == M_SNOOZE) begin
        m_mode = M_ALARM; m_end = tn + P_ALARM;
      end else begin
        m_mode = M_IDLE; m_used = 0;
      end
    end
    m_tick = tn;
  endtask

  // One clock: present tick strobe, advance model and DUT, clear pulses,
  // then advance the wall clock if this was a tick.
  task automatic cyc(input bit tk);
    bus.tick_1hz = tk;
    model_step();
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.stop     = 1'b0;
    bus.snooze   = 1'b0;
    if (tk) set_time(sod + 1);
  endtask

  task automatic load_alarm(input int t);
    bus.hour_set   = 6'(t / 3600);
    bus.minute_set = 6'((t / 60) % 60);
    bus.second_set = 6'(t % 60);
    bus.alarm_set  = 1'b1;
    cyc(1'b0);
    bus.alarm_set  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs_vec !== 7'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=%b", i, obs_vec, 7'd0);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alarm();
    bus.hour_set = 6'd7; bus.minute_set = 6'd30; bus.second_set = 6'd0;
    bus.alarm_set = 1'b1;
    cyc(1'b0); cyc(1'b0);
    bus.alarm_set = 1'b0;
    bus.alarm_arm = 1'b1;
    bus.chime_en  = 1'b0;
    set_time(7 * 3600 + 30 * 60 - 2);
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < 3; g++) begin
        cyc(g == 0);
        vectors++;
        if (obs_vec !== exp_vec()) begin
          miscompares++;
          $display("FAIL alarm_sweep i=%0d g=%0d got=%b want=%b", i, g, obs_vec, exp_vec());
        end
        if (g == 0 && i == 2) begin
          vectors++;
          if (bus.sound_en !== 1'b1 || bus.tone_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL alarm_start got sound=%b tone=%0d want sound=1 tone=2", bus.sound_en, bus.tone_sel);
          end
        end
        if (g == 0 && i == 7) begin
          vectors++;
          if (bus.sound_en !== 1'b0) begin
            miscompares++;
            $display("FAIL alarm_end got sound=%b want 0", bus.sound_en);
          end
        end
      end
    end
  endtask

  task automatic test_chime();
    bus.alarm_arm = 1'b0;
    bus.chime_en  = 1'b1;
    set_time(12 * 3600 + 59 * 60 + 59);
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < 2; g++) begin
        cyc(g == 0);
        vectors++;
        if (obs_vec !== exp_vec()) begin
          miscompares++;
          $display("FAIL chime_on i=%0d g=%0d got=%b want=%b", i, g, obs_vec, exp_vec());
        end
        if (g == 0 && (i == 0 || i == 3)) begin
          vectors++;
          if (bus.tone_sel !== ((i == 0) ? 2'd1 : 2'd0)) begin
            miscompares++;
            $display("FAIL chime_tone i=%0d got=%0d want=%0d", i, bus.tone_sel, (i == 0) ? 1 : 0);
          end
        end
      end
    end
    bus.chime_en = 1'b0;
    set_time(12 * 3600 + 59 * 60 + 59);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      vectors++;
      if (obs_vec !== 7'd0 || obs_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL chime_off i=%0d got=%b want=%b", i, obs_vec, 7'd0);
      end
    end
  endtask

  task automatic test_snooze();
    load_alarm(6 * 3600);
    bus.alarm_arm = 1'b1;
    set_time(6 * 3600);
    cyc(1'b1);
    cyc(1'b0);
    bus.snooze = 1'b1;
    cyc(1'b0);
    vectors++;
    if (bus.snooze_pend !== 1'b1 || obs_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL snooze_enter got=%b want=%b", obs_vec, exp_vec());
    end
    for (int i = 1; i <= 4; i++) begin
      for (int g = 0; g < 2; g++) begin
        cyc(g == 0);
        vectors++;
        if (obs_vec !== exp_vec()) begin
          miscompares++;
          $display("FAIL snooze_wait i=%0d g=%0d got=%b want=%b", i, g, obs_vec, exp_vec());
        end
      end
    end
    vectors++;
    if (bus.state_o !== 2'd2) begin
      miscompares++;
      $display("FAIL snooze_rering got state=%0d want 2", bus.state_o);
    end
    bus.snooze = 1'b1;
    cyc(1'b0);
    vectors++;
    if (bus.state_o !== 2'd0 || bus.snooze_pend !== 1'b0 || obs_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL snooze_limit got=%b want=%b", obs_vec, exp_vec());
    end
  endtask

  task automatic test_preempt();
    load_alarm(8 * 3600 + 59 * 60 + 59);
    bus.alarm_arm = 1'b1;
    bus.chime_en  = 1'b1;
    set_time(7 * 3600 + 59 * 60 + 59);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    vectors++;
    if (bus.tone_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL preempt_chime got tone=%0d want 1", bus.tone_sel);
    end
    set_time(8 * 3600 + 59 * 60 + 59);
    cyc(1'b1);
    vectors++;
    if (bus.tone_sel !== 2'd2 || obs_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL preempt_alarm got=%b want=%b", obs_vec, exp_vec());
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0);
      cyc(1'b1);
      vectors++;
      if (obs_vec !== exp_vec() || bus.sound_en !== ((i < 5) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL preempt_reload i=%0d got=%b want=%b", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_stop_snooze();
    bus.chime_en = 1'b0;
    set_time(8 * 3600 + 59 * 60 + 59);
    cyc(1'b1);
    bus.stop   = 1'b1;
    bus.snooze = 1'b1;
    cyc(1'b0);
    vectors++;
    if (bus.state_o !== 2'd0 || bus.snooze_pend !== 1'b0 || obs_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL stop_and_snooze got=%b want=%b", obs_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int a;
    for (int ep = 0; ep < 8; ep++) begin
      a = int'($urandom_range(0, 86399));
      if ($urandom_range(0, 2) == 0) a = (a / 3600) * 3600 + 3599;
      load_alarm(a);
      bus.alarm_arm = ($urandom_range(0, 3) != 0);
      bus.chime_en  = $urandom_range(0, 1) == 1;
      set_time(a - int'($urandom_range(0, 3)));
      for (int c = 0; c < 150; c++) begin
        bus.stop      = ($urandom_range(0, 39) == 0);
        bus.snooze    = ($urandom_range(0, 11) == 0);
        bus.alarm_set = ($urandom_range(0, 199) == 0);
        cyc($urandom_range(0, 2) == 0);
        bus.alarm_set = 1'b0;
        vectors++;
        if (obs_vec !== exp_vec()) begin
          miscompares++;
          $display("FAIL random ep=%0d c=%0d got=%b want=%b", ep, c, obs_vec, exp_vec());
        end
      end
    end
  endtask

  task automatic test_rst_mid_alarm();
    bus.chime_en  = 1'b0;
    bus.alarm_arm = 1'b1;
    load_alarm(10 * 3600);
    set_time(10 * 3600 - 1);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    vectors++;
    if (bus.state_o !== 2'd2 || obs_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL rst_pre_ring got=%b want=%b", obs_vec, exp_vec());
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (bus.sound_en !== 1'b0 || bus.LEDAlarm !== 1'b0 || bus.state_o !== 2'd0 || obs_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL rst_async got=%b want=%b", obs_vec, exp_vec());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_time(0);
    cyc(1'b1);
    vectors++;
    if (bus.state_o !== 2'd2 || obs_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL rst_alarm_regs got=%b want=%b", obs_vec, exp_vec());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.tick_1hz   = 1'b0;
    bus.hour       = '0;
    bus.minute     = '0;
    bus.second     = '0;
    bus.hour_set   = '0;
    bus.minute_set = '0;
    bus.second_set = '0;
    bus.alarm_set  = 1'b0;
    bus.alarm_arm  = 1'b0;
    bus.chime_en   = 1'b0;
    bus.stop       = 1'b0;
    bus.snooze     = 1'b0;
    test_reset();
    test_alarm();
    test_chime();
    test_snooze();
    test_preempt();
    test_stop_snooze();
    test_random();
    test_rst_mid_alarm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
